// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, default sizes and write-port arbitration for regfile_mp
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int DEPTH_DEF = 32;
  typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;
  function automatic logic [1:0] winPort(input logic [1:0] hit);
    return hit[1] ? 2'b11 : {hit[0], 1'b0};
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with issue set, write clear and indexed sweep clear
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int NR = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              setVld,
  input  logic [AW-1:0]     setIdx,
  input  logic [DEPTH-1:0]  clrMask,
  input  logic              clrIdxVld,
  input  logic [AW-1:0]     clrIdx,
  input  logic [NR*AW-1:0]  raddr,
  output logic [NR-1:0]     rbusy
);
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] setMask;
  assign setMask = (setVld && !(ZERO_REG != 0 && setIdx == '0)) ? DEPTH'(1) << setIdx : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else if (clrIdxVld) busy[clrIdx] <= 1'b0;
    else busy <= (busy & ~clrMask) | setMask;
  for (genvar i = 0; i < NR; i++) begin : g_r
    assign rbusy[i] = busy[raddr[i*AW +: AW]];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard and clear engine; REGFILE_BYPASS_EN adds write-to-read bypass
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NR = 2,
  parameter int NW = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NR*AW-1:0]  raddr,
  output logic [NR*XLEN-1:0] rdata,
  output logic [NR-1:0]     rbusy,
  input  logic [NW-1:0]     we,
  input  logic [NW*AW-1:0]  waddr,
  input  logic [NW*XLEN-1:0] wdata,
  input  logic              iss_vld,
  input  logic [AW-1:0]     iss_rd,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);
  state_t state;
  logic [AW-1:0] idx;
  logic clearing;
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0] waPad [2];
  logic [XLEN-1:0] wdPad [2];
  logic [1:0] wv;
  logic [1:0] wWin [DEPTH];
  logic [DEPTH-1:0] wMask;
  logic [NR-1:0] sbBusy;
  assign clearing = state == ST_CLEAR;
  assign clr_busy = clearing;
  // Ports beyond NW are padded to zero so arbitration always sees two ports.
  for (genvar j = 0; j < 2; j++) begin : g_w
    if (j < NW) begin : g_on
      assign waPad[j] = waddr[j*AW +: AW];
      assign wdPad[j] = wdata[j*XLEN +: XLEN];
      assign wv[j] = we[j] && !clearing && !(ZERO_REG != 0 && waPad[j] == '0);
    end else begin : g_off
      assign waPad[j] = '0;
      assign wdPad[j] = '0;
      assign wv[j] = 1'b0;
    end
  end
  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      wWin[a] = winPort({wv[1] && waPad[1] == AW'(a), wv[0] && waPad[0] == AW'(a)});
      wMask[a] = wWin[a][1];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    else if (clearing) mem[idx] <= '0;
    else for (int a = 0; a < DEPTH; a++) if (wWin[a][1]) mem[a] <= wdPad[wWin[a][0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      idx <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= clearing && idx == AW'(DEPTH - 1);
      if (clearing) begin
        idx <= idx + 1'b1;
        if (idx == AW'(DEPTH - 1)) state <= ST_IDLE;
      end else if (clr_req) begin
        state <= ST_CLEAR;
        idx <= '0;
      end
    end
  regfile_scoreboard #(.DEPTH(DEPTH), .NR(NR), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .setVld(iss_vld && !clearing),
    .setIdx(iss_rd),
    .clrMask(wMask),
    .clrIdxVld(clearing),
    .clrIdx(idx),
    .raddr(raddr),
    .rbusy(sbBusy)
  );
  for (genvar i = 0; i < NR; i++) begin : g_r
    logic [AW-1:0] ra;
    logic [1:0] rw;
    assign ra = raddr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign rw = winPort({wv[1] && waPad[1] == ra, wv[0] && waPad[0] == ra});
`else
    assign rw = 2'b00;
`endif
    assign rdata[i*XLEN +: XLEN] = rw[1] ? wdPad[rw[0]] : (ZERO_REG != 0 && ra == '0) ? '0 : mem[ra];
    assign rbusy[i] = sbBusy[i] & ~rw[1];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default parameters)
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] raddr;
  logic [63:0] rdata;
  logic [1:0] rbusy;
  logic [1:0] we;
  logic [9:0] waddr;
  logic [63:0] wdata;
  logic iss_vld;
  logic [4:0] iss_rd;
  logic clr_req;
  logic clr_busy;
  logic clr_done;
  int nTests = 0;
  int nFail = 0;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .iss_vld(iss_vld), .iss_rd(iss_rd),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      nTests++;
      if (rdata !== 64'h0 || rbusy !== 2'b00 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin
        nFail++;
        $display("FAIL reset a=%0d rdata=%h rbusy=%b clr_busy=%b clr_done=%b, want all zero", a, rdata, rbusy, clr_busy, clr_done);
      end
    end
  endtask

  task automatic test_collision;
    tick;
    we = 2'b11; waddr = {5'd5, 5'd5}; wdata = {32'hBBBB, 32'hAAAA}; raddr = {5'd5, 5'd5};
    #1;
    nTests++;
    if (rdata[31:0] !== (BYP ? 32'hBBBB : 32'h0)) begin
      nFail++;
      $display("FAIL collision_same_cycle rdata=%h want %h", rdata[31:0], BYP ? 32'hBBBB : 32'h0);
    end
    tick;
    we = 2'b11; waddr = {5'd9, 5'd8}; wdata = {32'h99, 32'h88};
    #1;
    nTests++;
    if (rdata !== {32'hBBBB, 32'hBBBB}) begin
      nFail++;
      $display("FAIL collision_port1_wins rdata=%h want %h", rdata, {32'hBBBB, 32'hBBBB});
    end
    tick;
    we = 2'b00; raddr = {5'd9, 5'd8};
    #1;
    nTests++;
    if (rdata !== {32'h99, 32'h88}) begin
      nFail++;
      $display("FAIL dual_write rdata=%h want %h", rdata, {32'h99, 32'h88});
    end
  endtask

  task automatic test_zero_reg;
    tick;
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hDEAD}; raddr = {5'd0, 5'd0};
    #1;
    nTests++;
    if (rdata[31:0] !== 32'h0) begin
      nFail++;
      $display("FAIL zero_reg_same_cycle rdata=%h want 0", rdata[31:0]);
    end
    tick;
    we = 2'b00;
    #1;
    nTests++;
    if (rdata[31:0] !== 32'h0) begin
      nFail++;
      $display("FAIL zero_reg_after rdata=%h want 0", rdata[31:0]);
    end
  endtask

  task automatic test_bypass;
    tick;
    we = 2'b10; waddr = {5'd7, 5'd0}; wdata = {32'h1234, 32'h0}; raddr = {5'd7, 5'd8};
    #1;
    nTests++;
    if (rdata[63:32] !== (BYP ? 32'h1234 : 32'h0) || rdata[31:0] !== 32'h88) begin
      nFail++;
      $display("FAIL bypass_same_cycle rdata=%h want %h/%h", rdata, BYP ? 32'h1234 : 32'h0, 32'h88);
    end
    tick;
    we = 2'b00;
    #1;
    nTests++;
    if (rdata[63:32] !== 32'h1234) begin
      nFail++;
      $display("FAIL bypass_next_cycle rdata=%h want 1234", rdata[63:32]);
    end
  endtask

  task automatic test_scoreboard;
    tick;
    iss_vld = 1'b1; iss_rd = 5'd3; raddr = {5'd0, 5'd3};
    #1;
    nTests++;
    if (rbusy !== 2'b00) begin
      nFail++;
      $display("FAIL busy_set_latency rbusy=%b want 00", rbusy);
    end
    tick;
    iss_vld = 1'b1; iss_rd = 5'd3; we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h33};
    #1;
    nTests++;
    if (rbusy[0] !== !BYP) begin
      nFail++;
      $display("FAIL busy_set rbusy=%b want %b", rbusy[0], !BYP);
    end
    tick;
    iss_vld = 1'b0; we = 2'b00;
    #1;
    nTests++;
    if (rbusy[0] !== 1'b1) begin
      nFail++;
      $display("FAIL busy_set_wins rbusy=%b want 1", rbusy[0]);
    end
    tick;
    we = 2'b10; waddr = {5'd3, 5'd0}; wdata = {32'h44, 32'h0};
    iss_vld = 1'b1; iss_rd = 5'd0;
    tick;
    we = 2'b00; iss_vld = 1'b0;
    #1;
    nTests++;
    if (rbusy !== 2'b00 || rdata[31:0] !== 32'h44) begin
      nFail++;
      $display("FAIL busy_clear rbusy=%b rdata=%h want 00/44", rbusy, rdata[31:0]);
    end
  endtask

  task automatic test_clear;
    int cycles = 0;
    int dones = 0;
    int doneAt = -1;
    for (int a = 1; a < 32; a++) begin
      tick;
      we = 2'b01; waddr = {5'd0, 5'(a)}; wdata = {32'h0, 32'h100 + 32'(a)};
    end
    tick;
    we = 2'b00; iss_vld = 1'b1; iss_rd = 5'd4; raddr = {5'd4, 5'd31};
    tick;
    iss_vld = 1'b0;
    #1;
    nTests++;
    if (rdata !== {32'h104, 32'h11F} || rbusy !== 2'b10) begin
      nFail++;
      $display("FAIL fill rdata=%h rbusy=%b want %h/10", rdata, rbusy, {32'h104, 32'h11F});
    end
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (clr_busy) cycles++;
      if (clr_done) begin
        dones++;
        doneAt = k;
      end
      we = 2'b00; iss_vld = 1'b0; clr_req = 1'b0;
      if (k == 10) begin
        we = 2'b01; waddr = {5'd0, 5'd2}; wdata = {32'h0, 32'hCAFE};
        iss_vld = 1'b1; iss_rd = 5'd1;
      end
      if (k == 20) clr_req = 1'b1;
      tick;
    end
    we = 2'b00; iss_vld = 1'b0; clr_req = 1'b0;
    nTests++;
    if (cycles !== 32 || dones !== 1 || doneAt !== 32) begin
      nFail++;
      $display("FAIL clear_timing busy_cycles=%0d dones=%0d done_at=%0d want 32/1/32", cycles, dones, doneAt);
    end
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      #1;
      nTests++;
      if (rdata !== 64'h0 || rbusy !== 2'b00) begin
        nFail++;
        $display("FAIL clear_contents a=%0d rdata=%h rbusy=%b want 0/00", a, rdata, rbusy);
      end
    end
  endtask

  task automatic test_clear_reset;
    int dones = 0;
    tick;
    we = 2'b11; waddr = {5'd6, 5'd5}; wdata = {32'h66, 32'h55}; raddr = {5'd6, 5'd5};
    tick;
    we = 2'b00;
    #1;
    nTests++;
    if (rdata !== {32'h66, 32'h55}) begin
      nFail++;
      $display("FAIL refill rdata=%h want %h", rdata, {32'h66, 32'h55});
    end
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick;
    nTests++;
    if (clr_busy !== 1'b1) begin
      nFail++;
      $display("FAIL clear_midway clr_busy=%b want 1", clr_busy);
    end
    rst_n = 1'b0;
    #1;
    nTests++;
    if (clr_busy !== 1'b0 || rdata !== 64'h0) begin
      nFail++;
      $display("FAIL reset_abort clr_busy=%b rdata=%h want 0/0", clr_busy, rdata);
    end
    tick;
    tick;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (clr_done) dones++;
    end
    nTests++;
    if (dones !== 0 || clr_busy !== 1'b0 || rdata !== 64'h0) begin
      nFail++;
      $display("FAIL reset_no_done dones=%0d clr_busy=%b rdata=%h want 0/0/0", dones, clr_busy, rdata);
    end
  endtask

  initial begin
    rst_n = 1'b0; raddr = '0; we = '0; waddr = '0; wdata = '0;
    iss_vld = 1'b0; iss_rd = '0; clr_req = 1'b0;
    #12;
    test_reset;
    rst_n = 1'b1;
    test_reset;
    test_collision;
    test_zero_reg;
    test_bypass;
    test_scoreboard;
    test_clear;
    test_clear_reset;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
